// File: rtl/bloons_pkg.sv
// Shared defaults and the round state encoding for the bloons round controller.
package bloons_pkg;

  localparam int NUM_BLOONS_DEF = 32;
  localparam int ROUND_MAX_DEF  = 40;
  localparam int CNT_W          = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_END    = 3'd3,
    ST_LOST   = 3'd4,
    ST_WON    = 3'd5
  } round_state_t;

endpackage

// File: rtl/popcount_nb.sv
// Combinational population count of a bloon-slot vector; result wide enough for one full round.
module popcount_nb
  import bloons_pkg::*;
#(
  parameter int WIDTH = NUM_BLOONS_DEF
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CNT_W-1:0] count
);

  // Ripple sum of all set bits
  always_comb begin
    count = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      count = count + {{(CNT_W-1){1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/round_controller.sv
// Tower-defence round sequencer: launches rounds, tallies pops/leaks per slot once,
// and ends a round on full completion, timeout, or loss of all lives.
module round_controller
  import bloons_pkg::*;
#(
  parameter int          NUM_BLOONS  = NUM_BLOONS_DEF,
  parameter int          ROUND_MAX   = ROUND_MAX_DEF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_round,
  input  logic [NUM_BLOONS-1:0] pop,
  input  logic [NUM_BLOONS-1:0] leak,
  input  logic [7:0]            lives,
  output logic                  start_reset,
  output logic                  bloonpause,
  output logic [7:0]            round_num,
  output logic                  round_done,
  output logic [5:0]            pops_round,
  output logic [5:0]            leaks_round,
  output logic                  game_over,
  output logic                  game_won
);

  round_state_t          state_r;
  round_state_t          state_next_s;
  logic                  start_prev_r;
  logic [NUM_BLOONS-1:0] done_mask_r;
  logic [31:0]           timer_r;
  logic [NUM_BLOONS-1:0] pop_new_s;
  logic [NUM_BLOONS-1:0] leak_new_s;
  logic [CNT_W-1:0]      pop_cnt_s;
  logic [CNT_W-1:0]      leak_cnt_s;
  logic                  start_edge_s;

  assign start_edge_s = start_round & ~start_prev_r;

  // First pulse per slot only; a simultaneous pop and leak is a leak
  always_comb begin
    pop_new_s  = {NUM_BLOONS{1'b0}};
    leak_new_s = {NUM_BLOONS{1'b0}};
    if (state_r == ST_RUN) begin
      leak_new_s = leak & ~done_mask_r;
      pop_new_s  = pop & ~leak & ~done_mask_r;
    end else begin
      leak_new_s = {NUM_BLOONS{1'b0}};
      pop_new_s  = {NUM_BLOONS{1'b0}};
    end
  end

  popcount_nb #(.WIDTH(NUM_BLOONS)) u_pop_cnt  (.bits(pop_new_s),  .count(pop_cnt_s));
  popcount_nb #(.WIDTH(NUM_BLOONS)) u_leak_cnt (.bits(leak_new_s), .count(leak_cnt_s));

  // Next-state logic; running out of lives outranks completion and timeout
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) state_next_s = ST_LAUNCH;
        else              state_next_s = ST_IDLE;
      end
      ST_LAUNCH: state_next_s = ST_RUN;
      ST_RUN: begin
        if (lives == 8'd0)                                      state_next_s = ST_LOST;
        else if ((&done_mask_r) || (timer_r == TIMEOUT_CYC - 32'd1)) state_next_s = ST_END;
        else                                                    state_next_s = ST_RUN;
      end
      ST_END: begin
        if (round_num == 8'(ROUND_MAX)) state_next_s = ST_WON;
        else                            state_next_s = ST_IDLE;
      end
      ST_LOST: state_next_s = ST_LOST;
      ST_WON:  state_next_s = ST_WON;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, progress counters and registered outputs (decoded from the next state)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      start_prev_r <= 1'b0;
      done_mask_r  <= {NUM_BLOONS{1'b0}};
      timer_r      <= 32'd0;
      start_reset  <= 1'b0;
      bloonpause   <= 1'b0;
      round_done   <= 1'b0;
      round_num    <= 8'd1;
      pops_round   <= 6'd0;
      leaks_round  <= 6'd0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      start_prev_r <= start_round;
      start_reset  <= (state_next_s == ST_LAUNCH);
      bloonpause   <= (state_next_s == ST_RUN);
      round_done   <= (state_next_s == ST_END);
      game_over    <= game_over | (state_next_s == ST_LOST);
      game_won     <= game_won  | (state_next_s == ST_WON);
      if (state_next_s == ST_LAUNCH) begin
        done_mask_r <= {NUM_BLOONS{1'b0}};
        timer_r     <= 32'd0;
        pops_round  <= 6'd0;
        leaks_round <= 6'd0;
      end else if (state_r == ST_RUN) begin
        done_mask_r <= done_mask_r | pop_new_s | leak_new_s;
        timer_r     <= timer_r + 32'd1;
        pops_round  <= pops_round + pop_cnt_s;
        leaks_round <= leaks_round + leak_cnt_s;
      end
      if ((state_r == ST_END) && (state_next_s == ST_IDLE)) begin
        round_num <= round_num + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed scenarios plus randomized rounds
// checked against a per-slot bookkeeping model.
module tb_round_controller;

  localparam int          NB   = 32;
  localparam int          RMAX = 4;
  localparam logic [31:0] TO   = 32'd100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_round;
  logic [NB-1:0] pop;
  logic [NB-1:0] leak;
  logic [7:0]    lives;
  logic          start_reset;
  logic          bloonpause;
  logic [7:0]    round_num;
  logic          round_done;
  logic [5:0]    pops_round;
  logic [5:0]    leaks_round;
  logic          game_over;
  logic          game_won;

  int vec_cnt = 0;
  int err_cnt = 0;
  int m_round;

  round_controller #(.NUM_BLOONS(NB), .ROUND_MAX(RMAX), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start_round(start_round), .pop(pop), .leak(leak),
    .lives(lives), .start_reset(start_reset), .bloonpause(bloonpause), .round_num(round_num),
    .round_done(round_done), .pops_round(pops_round), .leaks_round(leaks_round),
    .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0; start_round = 1'b0; pop = '0; leak = '0; lives = 8'd5;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    m_round = 1;
  endtask

  task automatic do_launch;
    start_round = 1'b0; tick();
    start_round = 1'b1; tick();
    start_round = 1'b0; tick();
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start_round = 1'b0; pop = '0; leak = '0; lives = 8'd5;
    #12;
    vec_cnt++; if (round_num !== 8'd1) begin err_cnt++; $display("FAIL rst_round: got %0d exp 1", round_num); end
    vec_cnt++; if ({start_reset, bloonpause, round_done, game_over, game_won} !== 5'b0) begin
      err_cnt++; $display("FAIL rst_flags: got %b exp 00000", {start_reset, bloonpause, round_done, game_over, game_won}); end
    vec_cnt++; if ({pops_round, leaks_round} !== 12'd0) begin
      err_cnt++; $display("FAIL rst_counts: got %0d/%0d exp 0/0", pops_round, leaks_round); end
    @(negedge clk); reset_n = 1'b1; m_round = 1;
    tick(); tick();
    vec_cnt++; if (bloonpause !== 1'b0 || start_reset !== 1'b0) begin
      err_cnt++; $display("FAIL idle_hold: got pause=%b sr=%b exp 0/0", bloonpause, start_reset); end
  endtask

  task automatic test_launch;
    start_round = 1'b1; tick();
    vec_cnt++; if (start_reset !== 1'b1 || bloonpause !== 1'b0) begin
      err_cnt++; $display("FAIL launch_pulse: got sr=%b pause=%b exp 1/0", start_reset, bloonpause); end
    vec_cnt++; if (round_num !== 8'd1) begin err_cnt++; $display("FAIL launch_round: got %0d exp 1", round_num); end
    tick();
    vec_cnt++; if (start_reset !== 1'b0 || bloonpause !== 1'b1) begin
      err_cnt++; $display("FAIL launch_run: got sr=%b pause=%b exp 0/1", start_reset, bloonpause); end
    tick();
    vec_cnt++; if (start_reset !== 1'b0 || bloonpause !== 1'b1) begin
      err_cnt++; $display("FAIL launch_once: got sr=%b pause=%b exp 0/1", start_reset, bloonpause); end
    start_round = 1'b0;
  endtask

  task automatic test_directed_round;
    for (int i = 0; i < 30; i++) begin
      pop = '0; pop[i] = 1'b1; tick(); pop = '0;
      vec_cnt++; if (pops_round !== 6'(i + 1)) begin
        err_cnt++; $display("FAIL dir_pop%0d: got %0d exp %0d", i, pops_round, i + 1); end
    end
    leak[30] = 1'b1; leak[31] = 1'b1; tick(); leak = '0;
    vec_cnt++; if (pops_round !== 6'd30 || leaks_round !== 6'd2) begin
      err_cnt++; $display("FAIL dir_totals: got %0d/%0d exp 30/2", pops_round, leaks_round); end
    vec_cnt++; if (bloonpause !== 1'b1 || round_done !== 1'b0) begin
      err_cnt++; $display("FAIL dir_still_run: got pause=%b done=%b exp 1/0", bloonpause, round_done); end
    tick();
    vec_cnt++; if (round_done !== 1'b1 || bloonpause !== 1'b0) begin
      err_cnt++; $display("FAIL dir_end: got done=%b pause=%b exp 1/0", round_done, bloonpause); end
    tick(); m_round++;
    vec_cnt++; if (round_done !== 1'b0 || round_num !== 8'(m_round)) begin
      err_cnt++; $display("FAIL dir_next: got done=%b round=%0d exp 0/%0d", round_done, round_num, m_round); end
  endtask

  task automatic test_dedup;
    do_launch();
    vec_cnt++; if (pops_round !== 6'd0 || leaks_round !== 6'd0) begin
      err_cnt++; $display("FAIL dd_clear: got %0d/%0d exp 0/0", pops_round, leaks_round); end
    for (int k = 0; k < 3; k++) begin
      pop[5] = 1'b1; tick(); pop = '0; tick();
      vec_cnt++; if (pops_round !== 6'd1) begin err_cnt++; $display("FAIL dd_pop5_%0d: got %0d exp 1", k, pops_round); end
    end
    leak[5] = 1'b1; tick(); leak = '0;
    vec_cnt++; if (pops_round !== 6'd1 || leaks_round !== 6'd0) begin
      err_cnt++; $display("FAIL dd_leak5: got %0d/%0d exp 1/0", pops_round, leaks_round); end
    pop[7] = 1'b1; leak[7] = 1'b1; tick(); pop = '0; leak = '0;
    vec_cnt++; if (pops_round !== 6'd1 || leaks_round !== 6'd1) begin
      err_cnt++; $display("FAIL dd_both7: got %0d/%0d exp 1/1", pops_round, leaks_round); end
    pop = '1; tick(); pop = '0;
    vec_cnt++; if (pops_round !== 6'd31 || leaks_round !== 6'd1) begin
      err_cnt++; $display("FAIL dd_bulk: got %0d/%0d exp 31/1", pops_round, leaks_round); end
    tick();
    vec_cnt++; if (round_done !== 1'b1) begin err_cnt++; $display("FAIL dd_end: got %b exp 1", round_done); end
    tick(); m_round++;
    pop = '1; leak = '1; tick(); pop = '0; leak = '0;
    vec_cnt++; if (pops_round !== 6'd31 || leaks_round !== 6'd1 || round_num !== 8'(m_round)) begin
      err_cnt++; $display("FAIL dd_idle_ignore: got %0d/%0d r%0d exp 31/1 r%0d", pops_round, leaks_round, round_num, m_round); end
  endtask

  task automatic test_reset_mid_run;
    do_launch();
    vec_cnt++; if (round_num !== 8'd3) begin err_cnt++; $display("FAIL mr_round3: got %0d exp 3", round_num); end
    pop = 32'h0000_00FF; leak = 32'h0000_FF00; tick(); pop = '0; leak = '0;
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++; if (bloonpause !== 1'b0 || round_num !== 8'd1 || start_reset !== 1'b0) begin
      err_cnt++; $display("FAIL mr_state: got pause=%b round=%0d sr=%b exp 0/1/0", bloonpause, round_num, start_reset); end
    vec_cnt++; if (pops_round !== 6'd0 || leaks_round !== 6'd0) begin
      err_cnt++; $display("FAIL mr_counts: got %0d/%0d exp 0/0", pops_round, leaks_round); end
    @(negedge clk); reset_n = 1'b1; m_round = 1;
  endtask

  task automatic test_random_rounds;
    logic [NB-1:0] m_done;
    logic [NB-1:0] p;
    logic [NB-1:0] l;
    int m_p;
    int m_l;
    for (int r = 0; r < RMAX; r++) begin
      do_launch();
      vec_cnt++; if (round_num !== 8'(m_round) || bloonpause !== 1'b1) begin
        err_cnt++; $display("FAIL rr_launch%0d: got round=%0d pause=%b exp %0d/1", r, round_num, bloonpause, m_round); end
      m_done = '0; m_p = 0; m_l = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (m_done == '1) break;
        if (cyc < 40) begin
          p = $urandom & $urandom & $urandom;
          l = $urandom & $urandom & $urandom & $urandom;
        end else begin
          p = '1; l = '0;
        end
        pop = p; leak = l; tick(); pop = '0; leak = '0;
        for (int i = 0; i < NB; i++) begin
          if (!m_done[i] && (p[i] || l[i])) begin
            m_done[i] = 1'b1;
            if (l[i]) m_l++;
            else      m_p++;
          end
        end
        vec_cnt++; if (pops_round !== 6'(m_p) || leaks_round !== 6'(m_l) || bloonpause !== 1'b1) begin
          err_cnt++; $display("FAIL rr_count r%0d c%0d: got %0d/%0d pause=%b exp %0d/%0d/1",
                              r, cyc, pops_round, leaks_round, bloonpause, m_p, m_l); end
      end
      tick();
      vec_cnt++; if (round_done !== 1'b1 || bloonpause !== 1'b0) begin
        err_cnt++; $display("FAIL rr_end%0d: got done=%b pause=%b exp 1/0", r, round_done, bloonpause); end
      tick();
      if (m_round == RMAX) begin
        vec_cnt++; if (game_won !== 1'b1 || game_over !== 1'b0 || round_num !== 8'(RMAX) || round_done !== 1'b0) begin
          err_cnt++; $display("FAIL rr_won: got won=%b over=%b round=%0d done=%b exp 1/0/%0d/0",
                              game_won, game_over, round_num, round_done, RMAX); end
      end else begin
        m_round++;
        vec_cnt++; if (round_num !== 8'(m_round) || round_done !== 1'b0 || game_won !== 1'b0) begin
          err_cnt++; $display("FAIL rr_next%0d: got round=%0d done=%b won=%b exp %0d/0/0", r, round_num, round_done, game_won, m_round); end
      end
    end
    start_round = 1'b0; tick(); start_round = 1'b1; tick(); tick();
    vec_cnt++; if (start_reset !== 1'b0 || bloonpause !== 1'b0 || game_won !== 1'b1) begin
      err_cnt++; $display("FAIL won_sticky: got sr=%b pause=%b won=%b exp 0/0/1", start_reset, bloonpause, game_won); end
    start_round = 1'b0;
  endtask

  task automatic test_timeout;
    int run_cycles;
    apply_reset();
    start_round = 1'b0; tick();
    start_round = 1'b1; tick(); tick();
    run_cycles = 0;
    for (int n = 0; n < 300; n++) begin
      if (bloonpause === 1'b1) run_cycles++;
      if (round_done === 1'b1) break;
      tick();
    end
    vec_cnt++; if (round_done !== 1'b1 || run_cycles != 100) begin
      err_cnt++; $display("FAIL to_end: got done=%b run_cycles=%0d exp 1/100", round_done, run_cycles); end
    tick();
    vec_cnt++; if (round_num !== 8'd2) begin err_cnt++; $display("FAIL to_round: got %0d exp 2", round_num); end
    for (int k = 0; k < 5; k++) begin
      tick();
      vec_cnt++; if (start_reset !== 1'b0 || bloonpause !== 1'b0) begin
        err_cnt++; $display("FAIL to_no_relaunch%0d: got sr=%b pause=%b exp 0/0", k, start_reset, bloonpause); end
    end
    start_round = 1'b0;
  endtask

  task automatic test_lost;
    apply_reset();
    do_launch();
    pop = 32'h7FFF_FFFF; tick(); pop = '0;
    vec_cnt++; if (pops_round !== 6'd31) begin err_cnt++; $display("FAIL lost_pops: got %0d exp 31", pops_round); end
    leak[31] = 1'b1; tick(); leak = '0;
    vec_cnt++; if (leaks_round !== 6'd1 || bloonpause !== 1'b1) begin
      err_cnt++; $display("FAIL lost_leak: got %0d pause=%b exp 1/1", leaks_round, bloonpause); end
    lives = 8'd0; tick();
    vec_cnt++; if (game_over !== 1'b1 || round_done !== 1'b0 || bloonpause !== 1'b0 || round_num !== 8'd1) begin
      err_cnt++; $display("FAIL lost_enter: got over=%b done=%b pause=%b round=%0d exp 1/0/0/1",
                          game_over, round_done, bloonpause, round_num); end
    tick(); lives = 8'd5;
    start_round = 1'b0; tick(); start_round = 1'b1; tick(); tick();
    vec_cnt++; if (game_over !== 1'b1 || game_won !== 1'b0 || round_done !== 1'b0 || start_reset !== 1'b0 || round_num !== 8'd1) begin
      err_cnt++; $display("FAIL lost_sticky: got over=%b won=%b done=%b sr=%b round=%0d exp 1/0/0/0/1",
                          game_over, game_won, round_done, start_reset, round_num); end
    start_round = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_launch();
    test_directed_round();
    test_dedup();
    test_reset_mid_run();
    test_random_rounds();
    test_timeout();
    test_lost();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
